// File: rtl/ibus_cache_pkg.sv
// ----------------------------------------------------------------------------
// ibus_cache_pkg
//   Shared definitions for the ibus_cache instruction cache:
//     - state_t          : controller state encoding
//     - WORD_ALIGN_MASK  : clears the byte-offset bits of a fetch address
//     - WORD_BYTES       : address stride between consecutive cache lines
//     - idx_w / tag_w    : derived index and tag widths from LINES and AW
// ----------------------------------------------------------------------------
package ibus_cache_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FILL     = 2'd1,
        GAP      = 2'd2,
        PREFETCH = 2'd3
    } state_t;

    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] WORD_BYTES      = 32'd4;

    // Index width: one line per word, LINES is a power of two.
    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    // Tag width: significant address bits above the byte offset and index.
    function automatic int tag_w(input int aw, input int lines);
        return aw - 2 - $clog2(lines);
    endfunction

endpackage

// File: rtl/ibus_cache_mem.sv
// ----------------------------------------------------------------------------
// ibus_cache_mem
//   LINES x (TAG_W+32) tag/data storage with one read and one write port,
//   plus a valid-bit vector kept in flops so a flush clears every line in a
//   single cycle. The read port is combinational so a lookup completes in the
//   same cycle the address is presented.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (valid bits only)
//   flush             clear all valid bits on the next edge (beats a write)
//   rd_idx            read line index
//   rd_tag, rd_data   stored tag and word for rd_idx
//   rd_valid          valid bit for rd_idx
//   wr_en             write tag/data at wr_idx and mark the line valid
//   wr_idx, wr_tag, wr_data  write port
// ----------------------------------------------------------------------------
module ibus_cache_mem
    import ibus_cache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int TAG_W = 18,
    parameter int IDX_W = idx_w(LINES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data,
    output logic             rd_valid,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_data
);

    logic [TAG_W+31:0] ram [LINES];
    logic [LINES-1:0]  valid;

    // NOTE: the tag/data array has no reset; contents are meaningless until
    // the matching valid bit is set, and a reset would keep it out of RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[wr_idx] <= {wr_tag, wr_data};
        end
    end

    assign {rd_tag, rd_data} = ram[rd_idx];
    assign rd_valid          = valid[rd_idx];

    // Flush has priority so a fill completing in the flush cycle stays invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

endmodule

// File: rtl/ibus_cache.sv
// ----------------------------------------------------------------------------
// ibus_cache
//   Direct-mapped, read-only, one-word-per-line instruction cache between the
//   CPU instruction bus (slave side, s_*) and the SPI-flash fetcher (master
//   side, m_*). Wishbone classic on both sides.
//
//   Hit : s_ack one cycle after s_cyc is first seen.
//   Miss: m_cyc at the word-aligned address; on m_ack the line is written and
//         the word is returned to the CPU on the next cycle.
//   A GAP cycle after every ack covers the CPU's registered cyc drop.
//
// Optional feature (macro IBUS_CACHE_PREFETCH_EN):
//   after a demand fill the next sequential line is fetched into the cache
//   unless it is already present.
//
// Ports:
//   wb_clk, wb_rst_n   clock, asynchronous active-low reset
//   flush              one-cycle pulse, invalidates every line
//   s_adr, s_cyc       CPU fetch address / request
//   s_rdt, s_ack       instruction word / one-cycle acknowledge
//   m_adr, m_cyc       word-aligned fetch address / request to the fetcher
//   m_rdt, m_ack       fetched word / acknowledge from the fetcher
// ----------------------------------------------------------------------------
module ibus_cache
    import ibus_cache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int AW    = 24
) (
    input  logic        wb_clk,
    input  logic        wb_rst_n,
    input  logic        flush,
    input  logic [31:0] s_adr,
    input  logic        s_cyc,
    output logic [31:0] s_rdt,
    output logic        s_ack,
    output logic [31:0] m_adr,
    output logic        m_cyc,
    input  logic [31:0] m_rdt,
    input  logic        m_ack
);

    localparam int IDX_W = idx_w(LINES);
    localparam int TAG_W = tag_w(AW, LINES);

    state_t            state;
    logic [31:0]       rd_adr;
    logic [IDX_W-1:0]  rd_idx;
    logic [TAG_W-1:0]  lookup_tag;
    logic [TAG_W-1:0]  stored_tag;
    logic [31:0]       stored_word;
    logic              stored_valid;
    logic              lookup_hit;
    logic              wr_en;
    logic              unused_adr_bits;

    // The read port serves the CPU address while idle; during a fill it is
    // free, so it probes the next sequential line for the prefetch decision.
    always_comb begin
        // NOTE: default first so every path assigns rd_adr and no latch forms.
        rd_adr = s_adr;
`ifdef IBUS_CACHE_PREFETCH_EN
        if (state != IDLE) begin
            rd_adr = m_adr + WORD_BYTES;
        end
`endif
    end

    assign rd_idx     = rd_adr[2 +: IDX_W];
    assign lookup_tag = rd_adr[AW-1 -: TAG_W];

    // A flush in the lookup cycle forces a miss.
    assign lookup_hit = stored_valid && (stored_tag == lookup_tag) && !flush;

    // Demand fills and prefetches both write the line on m_ack.
    assign wr_en = m_cyc && m_ack && ((state == FILL) || (state == PREFETCH));

    // Byte offset and bits above AW play no part in indexing or tag compare.
    assign unused_adr_bits = ^{rd_adr[1:0], rd_adr[31:AW]};

    ibus_cache_mem #(
        .LINES (LINES),
        .TAG_W (TAG_W),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk      (wb_clk),
        .rst_n    (wb_rst_n),
        .flush    (flush),
        .rd_idx   (rd_idx),
        .rd_tag   (stored_tag),
        .rd_data  (stored_word),
        .rd_valid (stored_valid),
        .wr_en    (wr_en),
        .wr_idx   (m_adr[2 +: IDX_W]),
        .wr_tag   (m_adr[AW-1 -: TAG_W]),
        .wr_data  (m_rdt)
    );

    // NOTE: all controller state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state <= IDLE;
            s_ack <= 1'b0;
            s_rdt <= '0;
            m_cyc <= 1'b0;
            m_adr <= '0;
        end else begin
            s_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (s_cyc) begin
                        if (lookup_hit) begin
                            s_rdt <= stored_word;
                            s_ack <= 1'b1;
                            state <= GAP;
                        end else begin
                            m_adr <= s_adr & WORD_ALIGN_MASK;
                            m_cyc <= 1'b1;
                            state <= FILL;
                        end
                    end
                end

                FILL: begin
                    if (m_ack) begin
                        m_cyc <= 1'b0;
                        // A CPU that abandoned the fetch gets no ack.
                        if (s_cyc) begin
                            s_rdt <= m_rdt;
                            s_ack <= 1'b1;
                        end
`ifdef IBUS_CACHE_PREFETCH_EN
                        if (lookup_hit) begin
                            state <= GAP;
                        end else begin
                            m_adr <= m_adr + WORD_BYTES;
                            state <= PREFETCH;
                        end
`else
                        state <= GAP;
`endif
                    end
                end

`ifdef IBUS_CACHE_PREFETCH_EN
                // m_cyc is dropped for one cycle between the demand fill and
                // the prefetch so the fetcher sees two distinct bus cycles.
                PREFETCH: begin
                    if (!m_cyc) begin
                        m_cyc <= 1'b1;
                    end else if (m_ack) begin
                        m_cyc <= 1'b0;
                        state <= GAP;
                    end
                end
`endif

                GAP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ibus_cache.sv
// ----------------------------------------------------------------------------
// tb_ibus_cache
//   Scoreboard bench for ibus_cache. Stimulus pushes the expected fetcher
//   addresses and CPU words into queues; a negedge monitor pops and compares
//   whenever m_cyc rises or s_ack is seen. A small fetcher model answers each
//   m_cyc after IBUS_LAT cycles.
// ----------------------------------------------------------------------------
module tb_ibus_cache;

    localparam int IBUS_LAT = 40;

    logic        wb_clk = 1'b0;
    logic        wb_rst_n = 1'b1;
    logic        flush;
    logic        flush_stim = 1'b0;
    logic        flush_on_ack = 1'b0;
    logic [31:0] s_adr = '0;
    logic        s_cyc = 1'b0;
    logic [31:0] s_rdt;
    logic        s_ack;
    logic [31:0] m_adr;
    logic        m_cyc;
    logic [31:0] m_rdt = '0;
    logic        m_ack = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_madr_q[$];
    logic [31:0] exp_rdt_q[$];

    assign flush = flush_stim | (flush_on_ack & m_ack);

    always #5 wb_clk = ~wb_clk;

    ibus_cache dut (
        .wb_clk   (wb_clk),
        .wb_rst_n (wb_rst_n),
        .flush    (flush),
        .s_adr    (s_adr),
        .s_cyc    (s_cyc),
        .s_rdt    (s_rdt),
        .s_ack    (s_ack),
        .m_adr    (m_adr),
        .m_cyc    (m_cyc),
        .m_rdt    (m_rdt),
        .m_ack    (m_ack)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Flash contents seen by the fetcher model.
    function automatic logic [31:0] flash_word(input logic [31:0] a);
        case (a[23:0])
            24'h000100: return 32'h0000_0013;
            24'h000140: return 32'h0000_0067;
            24'h000200: return 32'hDEAD_BEEF;
            default:    return 32'h1000_0000 | {8'h00, a[23:0]};
        endcase
    endfunction

    // Fetcher model: m_ack appears IBUS_LAT cycles after m_cyc rises.
    int ibus_cnt = 0;
    always @(negedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            ibus_cnt = 0;
            m_ack    = 1'b0;
        end else if (m_ack) begin
            m_ack    = 1'b0;
            ibus_cnt = 0;
        end else if (m_cyc) begin
            ibus_cnt++;
            if (ibus_cnt == IBUS_LAT + 1) begin
                m_ack = 1'b1;
                m_rdt = flash_word(m_adr);
            end
        end else begin
            ibus_cnt = 0;
        end
    end

    // Monitor / scoreboard.
    logic m_cyc_q = 1'b0;
    logic s_ack_q = 1'b0;
    logic s_cyc_q = 1'b0;
    always @(negedge wb_clk) begin
        if (wb_rst_n) begin
            if (m_cyc && !m_cyc_q) begin
                if (exp_madr_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_m_cyc: got m_adr %h, expected no request", m_adr);
                end else begin
                    check("m_adr", m_adr, exp_madr_q.pop_front());
                end
            end
            if (s_ack) begin
                check("s_ack_back_to_back", {31'd0, s_ack_q}, 32'd0);
                check("s_ack_without_cyc", {31'd0, s_cyc_q}, 32'd1);
                if (exp_rdt_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_s_ack: got s_rdt %h, expected no ack", s_rdt);
                end else begin
                    check("s_rdt", s_rdt, exp_rdt_q.pop_front());
                end
            end
        end
        m_cyc_q = m_cyc;
        s_ack_q = s_ack;
        s_cyc_q = s_cyc;
    end

    // Wait until the fetcher side has been quiet for a few cycles.
    task automatic settle();
        int quiet = 0;
        int budget = 0;
        while (quiet < 4 && budget < 300) begin
            @(posedge wb_clk);
            #1;
            budget++;
            quiet = m_cyc ? 0 : quiet + 1;
        end
        if (quiet < 4) begin
            n_vec++;
            n_err++;
            $display("FAIL settle_timeout: got m_cyc %b, expected idle bus", m_cyc);
        end
    endtask

    // One CPU fetch; pf is the expected prefetch when that feature is built.
    task automatic fetch(input logic [31:0] adr, input logic [31:0] rdt,
                         input bit miss, input bit pf, input bit flush_req);
        int cyc = 0;
        exp_rdt_q.push_back(rdt);
        if (miss) exp_madr_q.push_back(adr & 32'hFFFF_FFFC);
`ifdef IBUS_CACHE_PREFETCH_EN
        if (pf) exp_madr_q.push_back((adr & 32'hFFFF_FFFC) + 32'd4);
`else
        if (pf) cyc = 0;
`endif
        @(posedge wb_clk);
        #1;
        s_adr      = adr;
        s_cyc      = 1'b1;
        flush_stim = flush_req;
        do begin
            @(posedge wb_clk);
            #1;
            flush_stim = 1'b0;
            cyc++;
        end while (!s_ack && cyc < 200);
        check("latency", 32'(cyc), miss ? 32'(IBUS_LAT + 2) : 32'd1);
        s_cyc = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values.
        #2 wb_rst_n = 1'b0;
        #1;
        check("rst_s_ack", {31'd0, s_ack}, 32'd0);
        check("rst_s_rdt", s_rdt, 32'd0);
        check("rst_m_cyc", {31'd0, m_cyc}, 32'd0);
        check("rst_m_adr", m_adr, 32'd0);
        repeat (3) @(posedge wb_clk);
        #2 wb_rst_n = 1'b1;
        settle();

        // adr          data          miss pf flush
        fetch(32'h0000_0100, 32'h0000_0013, 1, 1, 0); settle();  // cold miss
        fetch(32'h0000_0100, 32'h0000_0013, 0, 0, 0); settle();  // hit
        fetch(32'h0000_0100, 32'h0000_0013, 1, 1, 1); settle();  // flush on lookup
        fetch(32'h0000_0140, 32'h0000_0067, 1, 1, 0); settle();  // conflict
        fetch(32'h0000_0100, 32'h0000_0013, 1, 1, 0); settle();  // evicted
        flush_on_ack = 1'b1;
        fetch(32'h0000_0200, 32'hDEAD_BEEF, 1, 1, 0);            // flush with m_ack
        flush_on_ack = 1'b0;
        settle();
        fetch(32'h0000_0200, 32'hDEAD_BEEF, 1, 0, 0); settle();  // line stayed invalid

        // Asynchronous reset in the middle of a fill.
        exp_madr_q.push_back(32'h0000_0100);
        @(posedge wb_clk);
        #1;
        s_adr = 32'h0000_0100;
        s_cyc = 1'b1;
        repeat (10) @(posedge wb_clk);
        #3 wb_rst_n = 1'b0;
        #1;
        check("async_rst_m_cyc", {31'd0, m_cyc}, 32'd0);
        check("async_rst_s_ack", {31'd0, s_ack}, 32'd0);
        s_cyc = 1'b0;
        @(posedge wb_clk);
        #2 wb_rst_n = 1'b1;
        settle();

        fetch(32'h0000_0100, 32'h0000_0013, 1, 1, 0); settle();  // cache was cleared
        fetch(32'hFF00_0102, 32'h0000_0013, 0, 0, 0); settle();  // high bits, offset ignored
        fetch(32'hAB00_0383, 32'h1000_0380, 1, 1, 0); settle();  // high bits on m_adr

`ifdef IBUS_CACHE_PREFETCH_EN
        // Sequential fetch issued while the prefetch is outstanding.
        begin
            int cyc = 0;
            fetch(32'h0000_0300, 32'h1000_0300, 1, 1, 0);
            exp_rdt_q.push_back(32'h1000_0304);
            @(posedge wb_clk);
            #1;
            s_adr = 32'h0000_0304;
            s_cyc = 1'b1;
            do begin
                @(posedge wb_clk);
                #1;
                cyc++;
            end while (!s_ack && cyc < 200);
            check("pf_wait_ack", {31'd0, s_ack}, 32'd1);
            s_cyc = 1'b0;
            settle();
        end
`endif

        check("m_adr_queue_empty", 32'(exp_madr_q.size()), 32'd0);
        check("s_rdt_queue_empty", 32'(exp_rdt_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
